// File: rtl/idma_rw_coupler_if.sv
// AW channel bundle shared by the upstream and downstream sides of the
// read/write coupler. The master side drives payload, valid and the
// decoupled sideband; the slave side answers with ready.
interface idma_rw_coupler_if #(
    parameter type aw_t = logic
);
    aw_t  req;
    logic valid;
    logic ready;
    logic decouple;

    modport master (output req, output valid, output decouple, input ready);
    modport slave  (input req, input valid, input decouple, output ready);
endinterface

// File: rtl/idma_rw_coupler.sv
// Read/write coupler: holds back write AWs until the matching read data has
// started (first beat) or reached a beat threshold. Read-side events mint
// credits, credited AWs spend them; decoupled AWs and bypass mode skip the
// credit gate entirely.
module idma_rw_coupler #(
    parameter int unsigned NumAxInFlight = 2,
    parameter int unsigned AddrWidth     = 24,
    parameter int unsigned UserWidth     = 1,
    parameter int unsigned AxiIdWidth    = 1,
    parameter int unsigned LenWidth      = 8,
    parameter type         axi_aw_chan_t = logic,
    localparam int unsigned IdxW = (NumAxInFlight > 1) ? $clog2(NumAxInFlight) : 1,
    localparam int unsigned CntW = IdxW + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       testmode_i,
    input  logic [1:0]                 mode_i,
    input  logic [LenWidth-1:0]        threshold_i,
    input  logic                       r_rsp_valid_i,
    input  logic                       r_rsp_ready_i,
    input  logic                       r_rsp_first_i,
    input  logic                       r_rsp_last_i,
    input  logic                       r_decouple_aw_i,
    idma_rw_coupler_if.slave           aw_in,
    idma_rw_coupler_if.master          aw_out,
    output logic [CntW-1:0]            credit_o,
    output logic                       overflow_o,
    output logic                       busy_o
);

    localparam int unsigned BcW = LenWidth + 1;
    localparam logic [1:0]      ModeFirst  = 2'd1;
    localparam logic [1:0]      ModeThresh = 2'd2;
    localparam logic [CntW-1:0] MaxCnt     = CntW'(NumAxInFlight);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumAxInFlight - 1);
    localparam logic [BcW-1:0]  BcMax      = {BcW{1'b1}};

    // AW field widths only describe the payload type carried through here.
    localparam int unsigned unused_aw_widths = AddrWidth + UserWidth + AxiIdWidth;

    // The inline FIFO has no test-mode dependent structure.
    logic unused_testmode_s;
    assign unused_testmode_s = testmode_i;

    // State
    axi_aw_chan_t           mem_q [NumAxInFlight];
    axi_aw_chan_t           mem_d [NumAxInFlight];
    logic [NumAxInFlight-1:0] dec_q, dec_d;
    logic [IdxW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0]        credit_q, credit_d;
    logic                   overflow_q, overflow_d;
    logic [BcW-1:0]         bc_q, bc_d;
    logic                   released_q, released_d;

    // Combinational helpers
    logic                   rb_s, release_s, hit_s;
    logic [BcW:0]           bc_plus_s, thr_eff_s;
    logic                   bypass_s, head_valid_s, head_dec_s;
    logic                   aw_valid_s, aw_ready_s, push_s, pop_s, consume_s, rel_eff_s;

    // Release event detection from the observed R beats.
    always_comb begin
        rb_s       = r_rsp_valid_i & r_rsp_ready_i & ~r_decouple_aw_i;
        bc_plus_s  = {1'b0, bc_q} + {{BcW{1'b0}}, 1'b1};
        thr_eff_s  = (threshold_i == '0) ? {{BcW{1'b0}}, 1'b1} : {2'b00, threshold_i};
        hit_s      = (bc_plus_s == thr_eff_s);
        release_s  = 1'b0;
        bc_d       = bc_q;
        released_d = released_q;
        case (mode_i)
            ModeFirst: begin
                release_s = rb_s & r_rsp_first_i;
            end
            ModeThresh: begin
                if (rb_s) begin
                    release_s = ~released_q & (hit_s | r_rsp_last_i);
                    if (r_rsp_last_i) begin
                        bc_d       = '0;
                        released_d = 1'b0;
                    end else begin
                        if (bc_q != BcMax) begin
                            bc_d = bc_q + {{LenWidth{1'b0}}, 1'b1};
                        end else begin
                            bc_d = bc_q;
                        end
                        if (release_s) begin
                            released_d = 1'b1;
                        end else begin
                            released_d = released_q;
                        end
                    end
                end else begin
                    release_s = 1'b0;
                end
            end
            default: begin
                release_s = 1'b0;
            end
        endcase
    end

    // AW gating: head of the hold-back FIFO is offered once it may pass.
    always_comb begin
        bypass_s     = (mode_i != ModeFirst) && (mode_i != ModeThresh);
        head_valid_s = (fifo_cnt_q != '0);
        head_dec_s   = dec_q[rptr_q];
        aw_valid_s   = head_valid_s & (head_dec_s | bypass_s | (credit_q != '0));
        pop_s        = aw_valid_s & aw_out.ready;
        aw_ready_s   = (fifo_cnt_q != MaxCnt) | pop_s;
        push_s       = aw_in.valid & aw_ready_s;
        consume_s    = pop_s & ~head_dec_s & ~bypass_s;
        rel_eff_s    = release_s & ~bypass_s;
    end

    // FIFO storage, pointers and fill level.
    always_comb begin
        mem_d  = mem_q;
        dec_d  = dec_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_s) begin
            mem_d[wptr_q] = aw_in.req;
            dec_d[wptr_q] = aw_in.decouple;
            wptr_d        = (wptr_q == LastIdx) ? '0 : wptr_q + {{(IdxW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = (rptr_q == LastIdx) ? '0 : rptr_q + {{(IdxW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + {{(CntW-1){1'b0}}, 1'b1};
            2'b01:   fifo_cnt_d = fifo_cnt_q - {{(CntW-1){1'b0}}, 1'b1};
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Credit counter; a release at the ceiling is dropped and flagged.
    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        if (rel_eff_s && !consume_s) begin
            if (credit_q == MaxCnt) begin
                overflow_d = 1'b1;
            end else begin
                credit_d = credit_q + {{(CntW-1){1'b0}}, 1'b1};
            end
        end else if (consume_s && !rel_eff_s) begin
            credit_d = credit_q - {{(CntW-1){1'b0}}, 1'b1};
        end else begin
            credit_d = credit_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '{default: '0};
            dec_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            credit_q   <= '0;
            overflow_q <= 1'b0;
            bc_q       <= '0;
            released_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            dec_q      <= dec_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
            bc_q       <= bc_d;
            released_q <= released_d;
        end
    end

    assign aw_in.ready     = aw_ready_s;
    assign aw_out.valid    = aw_valid_s;
    assign aw_out.req      = mem_q[rptr_q];
    assign aw_out.decouple = head_dec_s;
    assign credit_o        = credit_q;
    assign overflow_o      = overflow_q;
    assign busy_o          = (fifo_cnt_q != '0) | (credit_q != '0) | (bc_q != '0) | released_q;

endmodule
